// File: rtl/rbm_input_binarizer_pkg.sv
// rtl/rbm_input_binarizer_pkg.sv - shared state encodings and constants for rbm_input_binarizer
package rbm_input_binarizer_pkg;

  localparam logic [1:0] ST_LOAD    = 2'd0;
  localparam logic [1:0] ST_PRESENT = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  // Feedback taps for x^8+x^6+x^5+x^4+1 on a left-shifting Fibonacci register
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam int DEFAULT_THRESHOLD = 128;

  function automatic logic lfsr_feedback(input logic [7:0] state);
    return ^(state & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/rbm_lfsr8.sv
// rtl/rbm_lfsr8.sv - 8-bit Fibonacci LFSR with enable and synchronous seed load
module rbm_lfsr8
  import rbm_input_binarizer_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk_i,
  input  logic       load_i,
  input  logic       en_i,
  output logic [7:0] rnd_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) lfsr_d = {lfsr_q[6:0], lfsr_feedback(lfsr_q)};
  end

  always_ff @(posedge clk_i) begin
    if (load_i) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign rnd_o = lfsr_q;

endmodule

// File: rtl/rbm_input_binarizer.sv
// rtl/rbm_input_binarizer.sv - binarizes a pixel stream into a visible vector and handshakes with an RBM layer
// Optional stochastic binarization against an LFSR is enabled by defining STOCHASTIC_BIN_EN.
module rbm_input_binarizer
  import rbm_input_binarizer_pkg::*;
#(
  parameter int         pixel_bitlength = 8,
  parameter int         input_dim       = 15,
  parameter int         threshold       = DEFAULT_THRESHOLD,
  parameter logic [7:0] lfsr_seed       = 8'hA5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [pixel_bitlength-1:0] pixel_in,
  input  logic                       pixel_valid,
  input  logic                       pixel_last,
  output logic                       pixel_ready,
  input  logic                       layer_finish,
  output logic                       data_valid,
  output logic [input_dim-1:0]       InputData,
  output logic                       layer_reset,
  output logic                       frame_err,
  output logic [15:0]                sample_count
);

  localparam int            IW       = (input_dim > 1) ? $clog2(input_dim) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(input_dim - 1);

  logic [1:0]           state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [input_dim-1:0] data_q, data_d;
  logic                 err_q, err_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 xfer;
  logic                 bin_bit;
  logic                 at_last;

  assign xfer    = pixel_valid && (state_q == ST_LOAD);
  assign at_last = (idx_q == LAST_IDX);

`ifdef STOCHASTIC_BIN_EN
  localparam int unused_threshold = threshold;
  logic [7:0] rnd;

  rbm_lfsr8 #(
    .SEED (lfsr_seed)
  ) u_lfsr (
    .clk_i  (clock),
    .load_i (reset),
    .en_i   (xfer),
    .rnd_o  (rnd)
  );

  assign bin_bit = (pixel_in > pixel_bitlength'(rnd));
`else
  localparam logic [7:0] unused_seed = lfsr_seed;
  assign bin_bit = (pixel_in >= pixel_bitlength'(threshold));
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_LOAD: begin
        if (xfer) begin
          data_d[idx_q] = bin_bit;
          if (pixel_last || at_last) begin
            // Zero-fill everything above the closing index so a short sample is clean
            for (int k = 0; k < input_dim; k++) begin
              if (k > int'(idx_q)) data_d[k] = 1'b0;
            end
            idx_d   = '0;
            state_d = ST_PRESENT;
            if (pixel_last != at_last) err_d = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      ST_PRESENT: begin
        if (layer_finish) begin
          state_d = ST_RELEASE;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      ST_RELEASE: begin
        state_d = ST_LOAD;
        data_d  = '0;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_LOAD;
      idx_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pixel_ready  = (state_q == ST_LOAD);
  assign data_valid   = (state_q == ST_PRESENT);
  assign layer_reset  = (state_q == ST_RELEASE);
  assign InputData    = data_q;
  assign frame_err    = err_q;
  assign sample_count = cnt_q;

endmodule

// File: tb/tb_rbm_input_binarizer.sv
// tb/tb_rbm_input_binarizer.sv - directed self-checking bench for rbm_input_binarizer
module tb_rbm_input_binarizer;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  pixel_in;
  logic        pixel_valid;
  logic        pixel_last;
  logic        pixel_ready;
  logic        layer_finish;
  logic        data_valid;
  logic [14:0] InputData;
  logic        layer_reset;
  logic        frame_err;
  logic [15:0] sample_count;

  int total = 0;
  int bad   = 0;

  rbm_input_binarizer dut (
    .clock        (clock),
    .reset        (reset),
    .pixel_in     (pixel_in),
    .pixel_valid  (pixel_valid),
    .pixel_last   (pixel_last),
    .pixel_ready  (pixel_ready),
    .layer_finish (layer_finish),
    .data_valid   (data_valid),
    .InputData    (InputData),
    .layer_reset  (layer_reset),
    .frame_err    (frame_err),
    .sample_count (sample_count)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] p, input logic last);
    pixel_in    = p;
    pixel_valid = 1'b1;
    pixel_last  = last;
    tick();
    pixel_valid = 1'b0;
    pixel_last  = 1'b0;
  endtask

  task automatic release_sample(input string tag, input logic [15:0] exp_cnt);
    layer_finish = 1'b1;
    tick();
    layer_finish = 1'b0;
    check_eq({tag, "_lr_hi"}, layer_reset, 1);
    check_eq({tag, "_dv_lo"}, data_valid, 0);
    check_eq({tag, "_cnt"}, sample_count, exp_cnt);
    tick();
    check_eq({tag, "_lr_lo"}, layer_reset, 0);
    check_eq({tag, "_ready"}, pixel_ready, 1);
    check_eq({tag, "_clr"}, InputData, 0);
  endtask

`ifdef STOCHASTIC_BIN_EN
  logic [7:0]  ref_lfsr;
  logic [14:0] exp_vec;

  task automatic send_model(input logic [7:0] p, input int k, input logic last);
    exp_vec[k] = (p > ref_lfsr);
    ref_lfsr   = {ref_lfsr[6:0], ^(ref_lfsr & 8'hB8)};
    send(p, last);
  endtask
`endif

  initial begin
    reset        = 1'b1;
    pixel_in     = 8'd0;
    pixel_valid  = 1'b0;
    pixel_last   = 1'b0;
    layer_finish = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_ready", pixel_ready, 1);
    check_eq("rst_dv", data_valid, 0);
    check_eq("rst_lr", layer_reset, 0);
    check_eq("rst_data", InputData, 0);
    check_eq("rst_err", frame_err, 0);
    check_eq("rst_cnt", sample_count, 0);

`ifdef STOCHASTIC_BIN_EN
    ref_lfsr = 8'hA5;
    exp_vec  = '0;
    for (int k = 0; k < 15; k++) send_model(8'd0, k, k == 14);
    check_eq("st_zero_dv", data_valid, 1);
    check_eq("st_zero", InputData, 0);
    release_sample("st_r1", 16'd1);
    exp_vec = '0;
    for (int k = 0; k < 15; k++) send_model(8'd255, k, k == 14);
    check_eq("st_ones", InputData, {17'd0, exp_vec});
    release_sample("st_r2", 16'd2);
    exp_vec = '0;
    for (int k = 0; k < 15; k++) send_model(8'd128, k, k == 14);
    check_eq("st_mid", InputData, {17'd0, exp_vec});
    check_eq("st_err", frame_err, 0);
    release_sample("st_r3", 16'd3);
`else
    for (int k = 0; k < 15; k++) send((k % 2 == 0) ? 8'd200 : 8'd50, k == 14);
    check_eq("full_dv", data_valid, 1);
    check_eq("full_data", InputData, 15'h5555);
    check_eq("full_err", frame_err, 0);
    check_eq("full_ready", pixel_ready, 0);

    pixel_valid = 1'b1;
    pixel_in    = 8'd0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("bp_ready", pixel_ready, 0);
      check_eq("bp_data", InputData, 15'h5555);
      check_eq("bp_dv", data_valid, 1);
    end
    release_sample("rel1", 16'd1);
    pixel_valid = 1'b0;

    for (int k = 0; k < 4; k++) send(8'd255, k == 3);
    check_eq("early_dv", data_valid, 1);
    check_eq("early_data", InputData, 15'h000F);
    check_eq("early_err", frame_err, 1);
    release_sample("rel2", 16'd2);

    for (int k = 0; k < 15; k++) send((k < 4) ? 8'd0 : 8'd255, k == 14);
    check_eq("after_early_data", InputData, 15'h7FF0);
    check_eq("after_early_err", frame_err, 1);
    release_sample("rel3", 16'd3);

    send(8'd127, 1'b0);
    send(8'd128, 1'b0);
    for (int k = 2; k < 15; k++) send(8'd0, k == 14);
    check_eq("thresh_data", InputData, 15'h0002);
    release_sample("rel4", 16'd4);

    for (int k = 0; k < 7; k++) send(8'd255, 1'b0);
    check_eq("mid_dv", data_valid, 0);
    reset = 1'b1;
    tick();
    check_eq("mid_rst_lr", layer_reset, 0);
    reset = 1'b0;
    check_eq("mid_rst_data", InputData, 0);
    check_eq("mid_rst_cnt", sample_count, 0);
    check_eq("mid_rst_err", frame_err, 0);
    check_eq("mid_rst_ready", pixel_ready, 1);
    tick();
    check_eq("mid_post_lr", layer_reset, 0);

    // No pixel_last on the 15th pixel: closes on index, flags a framing error
    for (int k = 0; k < 15; k++) send((k == 0) ? 8'd255 : 8'd0, 1'b0);
    check_eq("fresh_dv", data_valid, 1);
    check_eq("fresh_data", InputData, 15'h0001);
    check_eq("fresh_err", frame_err, 1);
    release_sample("rel5", 16'd1);
    send(8'd255, 1'b1);
    check_eq("next_data", InputData, 15'h0001);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rbm_input_binarizer.md
Name: rbm_input_binarizer

Overview:
Upstream feeder for a hidden RBM layer. Accepts a serial pixel stream (one intensity per cycle, valid/ready handshake), binarizes each pixel and packs it into the visible vector, then presents the vector with data_valid. Holds the vector until the layer reports finish. Then pulses the layer's reset so the layer restarts for the next sample.

Parameters:
- pixel_bitlength, 8: width of one pixel intensity.
- input_dim, 15: visible units per sample. Must equal the downstream layer's input width (784 in the full design).
- threshold, 128: deterministic binarization threshold. A pixel maps to 1 iff pixel >= threshold.
- lfsr_seed, 8'hA5: LFSR reset value, used only with the optional feature. Must be nonzero.

Ports:
- clock, input, 1: single clock; all logic is on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- pixel_in, input, pixel_bitlength: unsigned pixel intensity.
- pixel_valid, input, 1: pixel_in is valid this cycle.
- pixel_last, input, 1: qualified by pixel_valid; marks the final pixel of a sample.
- pixel_ready, output, 1: block accepts a pixel this cycle. A transfer happens when pixel_valid and pixel_ready are both 1.
- layer_finish, input, 1: the downstream layer's finish output.
- data_valid, output, 1: drives the layer's data_valid.
- InputData, output, input_dim: packed binary visible vector. Pixel k goes to bit k.
- layer_reset, output, 1: one-cycle pulse that clears the downstream layer.
- frame_err, output, 1: sticky framing-error flag.
- sample_count, output, 16: number of completed samples.

Behaviour:
- States:
  - LOAD: pixel_ready=1.
  - PRESENT: data_valid=1, pixel_ready=0.
  - RELEASE: layer_reset=1, pixel_ready=0, data_valid=0.
- Reset (synchronous): state=LOAD, pixel index=0, InputData=0, data_valid=0, layer_reset=0, frame_err=0, sample_count=0, LFSR=lfsr_seed.
- LOAD, on each transfer: InputData[idx] <= binarized bit, then idx increments.
- A sample closes on either of two conditions:
  - The transfer with idx==input_dim-1 arrives.
  - A transfer with pixel_last=1 arrives. Both conditions may occur together.
- On close: bits above idx are zero-filled, idx resets to 0, and the state moves to PRESENT.
- Latency: data_valid rises the cycle after the closing transfer.
- Framing errors: frame_err is set (and held) if either case occurs.
  - pixel_last=1 arrives with idx<input_dim-1. The sample closes early, zero-filled.
  - idx==input_dim-1 closes the sample without pixel_last. In this case the next accepted pixel starts a new sample.
- PRESENT: InputData and data_valid are held stable until layer_finish=1 is sampled.
  - The next cycle: data_valid=0, layer_reset=1, sample_count increments, state moves to RELEASE.
- RELEASE: lasts exactly one cycle, then moves to LOAD. pixel_ready returns to 1 the cycle after RELEASE.
- layer_finish is ignored outside PRESENT.
- InputData is cleared to 0 on entry to LOAD, so no stale bits survive a short sample.
- sample_count wraps from 16'hFFFF to 0.
- Mid-operation reset: aborts any partial sample or hold, with no layer_reset pulse generated. The system reset also clears the layer.
- Comparison is unsigned, at full pixel_bitlength.

Optional Feature:
- Macro: STOCHASTIC_BIN_EN.
- When defined: the bit is 1 iff pixel_in > rnd, where rnd is the current output of an 8-bit maximal LFSR (x^8+x^6+x^5+x^4+1) seeded with lfsr_seed.
  - The LFSR advances only on accepted transfers.
  - pixel_bitlength must be 8.
- When undefined: the threshold compare is used and no LFSR is instantiated.

Decomposition:
- Shared package/include holds:
  - state encodings (LOAD=2'd0, PRESENT=2'd1, RELEASE=2'd2);
  - the LFSR tap constant;
  - the default threshold.
- One natural sub-module: rbm_lfsr8, an 8-bit Fibonacci LFSR with enable and synchronous seed load. Instantiated only under STOCHASTIC_BIN_EN.

Test Plan:
- Full sample (input_dim=15): 15 pixels alternating 200/50, with pixel_last on #14.
  - data_valid is 1 the next cycle, InputData=15'b101010101010101, frame_err=0.
  - layer_finish held 3 cycles later gives a single-cycle layer_reset, then pixel_ready=1; sample_count=1.
- Backpressure: drive pixel_valid continuously during PRESENT.
  - pixel_ready=0 and no pixels are consumed; InputData is unchanged until after RELEASE.
- Early pixel_last: 4 pixels of 255, pixel_last on #3.
  - InputData=15'h000F, frame_err=1.
  - The next full sample shows the flag still 1 and bits 4..14 correct.
- Boundary threshold: pixels 127 and 128 at idx 0 and 1 → bit0=0, bit1=1.
- Reset mid-sample: reset after 7 pixels.
  - Outputs return to reset values, with no layer_reset pulse.
  - A fresh 15-pixel sample packs from bit 0.
- STOCHASTIC_BIN_EN:
  - 15 pixels of value 0 → all zeros.
  - Value 255 → all ones.
  - A value-128 stream shows LFSR-dependent bits that match a reference model from seed 8'hA5.
